// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
//  Module   : serial_adder
//  Brief    : Bit-serial adder/subtractor, LSB first, one bit per clock, with
//             start/ready/done handshake, carry-out and signed-overflow flags.
//  Revision : 1.0  initial release
// ============================================================================
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int                 c_cnt_w = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);
    localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_c;
    logic [c_cnt_w-1:0] r_cnt;
    logic [WIDTH-1:0]   r_res;

    logic               w_s;
    logic               w_cn;
    logic               w_last;
    logic [WIDTH-1:0]   w_res_next;

    assign w_s    = r_a[0] ^ r_b[0] ^ r_c;
    assign w_cn   = (r_a[0] & r_b[0]) | (r_a[0] & r_c) | (r_b[0] & r_c);
    assign w_last = (r_cnt == c_last);
    // New bit enters at the MSB; after WIDTH shifts the first bit sits at bit 0.
    assign w_res_next = WIDTH'({w_s, r_res} >> 1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_c     <= 1'b0;
            r_cnt   <= '0;
            r_res   <= '0;
            ready   <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        // Subtraction is a + ~b + 1: the +1 rides in as carry-in.
                        r_a     <= a;
                        r_b     <= sub ? ~b : b;
                        r_c     <= sub;
                        r_cnt   <= '0;
                        r_state <= S_SHIFT;
                        ready   <= 1'b0;
                        busy    <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                        ready   <= 1'b1;
                        busy    <= 1'b0;
                    end
                end
                S_SHIFT: begin
                    r_res <= w_res_next;
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_c   <= w_cn;
                    r_cnt <= r_cnt + c_one;
                    if (w_last) begin
                        ovf     <= r_c ^ w_cn;
                        cout    <= w_cn;
                        sum     <= w_res_next;
                        done    <= 1'b1;
                        ready   <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    ready   <= 1'b1;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_adder
//  Brief    : Scoreboard bench for serial_adder at WIDTH = 8, 1 and 16.
//  Revision : 1.0  initial release
// ============================================================================
module tb_serial_adder;

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        int          cyc;
    } exp_t;

    logic clk;
    logic reset;

    logic        start8, sub8, ready8, busy8, done8, cout8, ovf8;
    logic [7:0]  a8, b8, sum8;
    logic        start1, sub1, ready1, busy1, done1, cout1, ovf1;
    logic [0:0]  a1, b1, sum1;
    logic        start16, sub16, ready16, busy16, done16, cout16, ovf16;
    logic [15:0] a16, b16, sum16;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    exp_t q8[$];
    exp_t q1[$];
    exp_t q16[$];

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk(clk), .reset(reset), .start(start8), .sub(sub8), .a(a8), .b(b8),
        .ready(ready8), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
    );

    serial_adder #(.WIDTH(1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start1), .sub(sub1), .a(a1), .b(b1),
        .ready(ready1), .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1)
    );

    serial_adder #(.WIDTH(16)) u_dut16 (
        .clk(clk), .reset(reset), .start(start16), .sub(sub16), .a(a16), .b(b16),
        .ready(ready16), .busy(busy16), .done(done16), .sum(sum16), .cout(cout16), .ovf(ovf16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic check_result(input string tag, input exp_t e,
                                input logic [15:0] s, input logic c, input logic o);
        chk({tag, " sum"},  {16'd0, s}, {16'd0, e.sum});
        chk({tag, " cout"}, {31'd0, c}, {31'd0, e.cout});
        chk({tag, " ovf"},  {31'd0, o}, {31'd0, e.ovf});
        chk({tag, " done cycle"}, cyc, e.cyc);
    endtask

    task automatic unexpected_done(input string tag);
        tests++;
        fails++;
        $display("FAIL %s: done pulse at cycle %0d, expected none", tag, cyc);
    endtask

    // Monitors: pop the oldest expectation on every done pulse.
    always @(negedge clk) begin
        if (!reset && done8) begin
            if (q8.size() == 0) unexpected_done("w8 done");
            else check_result("w8", q8.pop_front(), {8'd0, sum8}, cout8, ovf8);
        end
    end

    always @(negedge clk) begin
        if (!reset && done1) begin
            if (q1.size() == 0) unexpected_done("w1 done");
            else check_result("w1", q1.pop_front(), {15'd0, sum1}, cout1, ovf1);
        end
    end

    always @(negedge clk) begin
        if (!reset && done16) begin
            if (q16.size() == 0) unexpected_done("w16 done");
            else check_result("w16", q16.pop_front(), sum16, cout16, ovf16);
        end
    end

    function automatic logic rdy(input int which);
        case (which)
            0:       return ready8;
            1:       return ready1;
            default: return ready16;
        endcase
    endfunction

    task automatic wait_ready(input int which);
        bit ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (rdy(which)) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL ready timeout: dut %0d ready=0, expected 1", which);
        end
    endtask

    // Drives one request at the current negedge; returns one cycle later with start low.
    task automatic issue(input int which, input logic [15:0] av, input logic [15:0] bv,
                         input logic s, input bit push, input logic [15:0] esum,
                         input logic ec, input logic eo);
        exp_t e;
        int   w;
        wait_ready(which);
        w = (which == 0) ? 8 : (which == 1) ? 1 : 16;
        e.sum = esum; e.cout = ec; e.ovf = eo; e.cyc = cyc + 1 + w;
        case (which)
            0:       begin a8  = av[7:0]; b8  = bv[7:0]; sub8  = s; start8  = 1'b1; end
            1:       begin a1  = av[0:0]; b1  = bv[0:0]; sub1  = s; start1  = 1'b1; end
            default: begin a16 = av;      b16 = bv;      sub16 = s; start16 = 1'b1; end
        endcase
        if (push) begin
            case (which)
                0:       q8.push_back(e);
                1:       q1.push_back(e);
                default: q16.push_back(e);
            endcase
        end
        @(negedge clk);
        start8 = 1'b0; start1 = 1'b0; start16 = 1'b0;
    endtask

    initial begin
        exp_t e;
        reset = 1'b1;
        {start8, sub8, a8, b8}     = '0;
        {start1, sub1, a1, b1}     = '0;
        {start16, sub16, a16, b16} = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        chk("reset ready", {31'd0, ready8}, 32'd1);
        chk("reset busy",  {31'd0, busy8},  32'd0);
        chk("reset done",  {31'd0, done8},  32'd0);
        chk("reset sum",   {24'd0, sum8},   32'd0);
        chk("reset cout",  {31'd0, cout8},  32'd0);
        chk("reset ovf",   {31'd0, ovf8},   32'd0);

        // Basic add with busy/ready timing across the whole operation.
        issue(0, 16'h3C, 16'h05, 1'b0, 1'b1, 16'h41, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("busy bit %0d", i), {31'd0, busy8}, 32'd1);
            if (i < 7) @(negedge clk);
        end
        @(negedge clk);
        chk("busy in done cycle",  {31'd0, busy8},  32'd0);
        chk("ready in done cycle", {31'd0, ready8}, 32'd1);

        issue(0, 16'hFF, 16'h01, 1'b0, 1'b1, 16'h00, 1'b1, 1'b0);
        issue(0, 16'h7F, 16'h01, 1'b0, 1'b1, 16'h80, 1'b0, 1'b1);
        issue(0, 16'h05, 16'h07, 1'b1, 1'b1, 16'hFE, 1'b0, 1'b0);
        issue(0, 16'h80, 16'h01, 1'b1, 1'b1, 16'h7F, 1'b1, 1'b1);

        // start held while busy is ignored; a start in the DONE cycle chains directly.
        wait_ready(0);
        a8 = 8'h11; b8 = 8'h22; sub8 = 1'b0; start8 = 1'b1;
        e.sum = 16'h33; e.cout = 1'b0; e.ovf = 1'b0; e.cyc = cyc + 9;
        q8.push_back(e);
        @(negedge clk);
        a8 = 8'hAA; b8 = 8'h55; sub8 = 1'b1;
        repeat (8) @(negedge clk);
        chk("ready in chained done", {31'd0, ready8}, 32'd1);
        a8 = 8'h10; b8 = 8'h20; sub8 = 1'b0;
        e.sum = 16'h30; e.cout = 1'b0; e.ovf = 1'b0; e.cyc = cyc + 9;
        q8.push_back(e);
        @(negedge clk);
        start8 = 1'b0;

        // Asynchronous reset mid-operation: no edge needed, no done afterwards.
        issue(0, 16'h12, 16'h34, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("abort ready", {31'd0, ready8}, 32'd1);
        chk("abort busy",  {31'd0, busy8},  32'd0);
        chk("abort sum",   {24'd0, sum8},   32'd0);
        chk("abort cout",  {31'd0, cout8},  32'd0);
        chk("abort ovf",   {31'd0, ovf8},   32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        issue(0, 16'h01, 16'h01, 1'b0, 1'b1, 16'h02, 1'b0, 1'b0);

        issue(1, 16'h1, 16'h1, 1'b0, 1'b1, 16'h0, 1'b1, 1'b1);
        issue(2, 16'hFFFF, 16'h0001, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);

        repeat (24) @(negedge clk);
        chk("w8 scoreboard drained",  q8.size(),  32'd0);
        chk("w1 scoreboard drained",  q1.size(),  32'd0);
        chk("w16 scoreboard drained", q16.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
